// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath slice: operation codes,
// operand-source selects and the multiply sequencer state encoding.
package alu_pkg;

    // ALUOp encoding; codes 12..15 pass the A-mux value through.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;

    // A-side operand sources.
    localparam logic [1:0] ASRC_A    = 2'd0;
    localparam logic [1:0] ASRC_PC   = 2'd1;
    localparam logic [1:0] ASRC_IMM  = 2'd2;
    localparam logic [1:0] ASRC_ZERO = 2'd3;

    // B-side operand sources.
    localparam logic [1:0] BSRC_B     = 2'd0;
    localparam logic [1:0] BSRC_INC   = 2'd1;
    localparam logic [1:0] BSRC_IMM   = 2'd2;
    localparam logic [1:0] BSRC_SHIFT = 2'd3;

    // Multiply sequencer states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

    // Two's-complement overflow: the result sign disagrees with the sign both
    // effective operands share (for SUB the caller passes the inverted B sign).
    function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                        input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage

// File: rtl/alu_datapath_unit_if.sv
// Bus bundle between the control/register-file side (master) and the
// ALU datapath slice (slave).
interface alu_datapath_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] Read1;
    logic [WIDTH-1:0] Read2;
    logic [WIDTH-1:0] ExImm;
    logic [WIDTH-1:0] Shifter;
    logic             AWrite;
    logic             BWrite;
    logic [1:0]       ALUAinput;
    logic [1:0]       ALUBinput;
    logic [3:0]       ALUOp;
    logic             ALUOutWrite;
    logic             Start;
    logic [WIDTH-1:0] ALUOut;
    logic             Zero;
    logic             OverFlow;
    logic [WIDTH-1:0] ALUOutReg;
    logic             ZeroReg;
    logic             OverFlowReg;
    logic             Busy;
    logic             Done;

    modport slave (
        input  PC, Read1, Read2, ExImm, Shifter, AWrite, BWrite,
               ALUAinput, ALUBinput, ALUOp, ALUOutWrite, Start,
        output ALUOut, Zero, OverFlow, ALUOutReg, ZeroReg, OverFlowReg,
               Busy, Done
    );

    modport master (
        output PC, Read1, Read2, ExImm, Shifter, AWrite, BWrite,
               ALUAinput, ALUBinput, ALUOp, ALUOutWrite, Start,
        input  ALUOut, Zero, OverFlow, ALUOutReg, ZeroReg, OverFlowReg,
               Busy, Done
    );
endinterface

// File: rtl/alu_iter_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per clock,
// WIDTH busy cycles, a one-cycle done pulse after the final iteration.
// 'last' and 'product' expose the final accumulator value on the completing
// edge so the parent can register it together with the sequencer.
module alu_iter_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               last,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

    mul_state_e         state_r;
    mul_state_e         state_next_s;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic [CNT_W-1:0]   count_r;
    logic               last_s;
    logic               done_r;

    // Accumulator plus the current partial product (multiplicand already shifted).
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Next-state logic; flags the iteration that completes the product.
    always_comb begin
        state_next_s = state_r;
        last_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_MUL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (count_r == '0) begin
                    state_next_s = ST_IDLE;
                    last_s       = 1'b1;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on launch, then one shift-add step per busy cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier_r <= multiplier;
                        acc_r    <= '0;
                        count_r  <= CNT_INIT;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r - CNT_W'(1);
                end
                default: begin
                    count_r <= '0;
                end
            endcase
        end
    end

    // Done pulses for the cycle following the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_r <= 1'b0;
        end else begin
            done_r <= last_s;
        end
    end

    assign busy    = (state_r == ST_MUL);
    assign last    = last_s;
    assign done    = done_r;
    assign product = acc_next_s;

endmodule

// File: rtl/alu_datapath_unit.sv
// Multicycle datapath slice: A/B operand registers, source muxes, a
// single-cycle ALU with Zero/OverFlow, an iterative multiplier and the
// result register shared by both paths.
module alu_datapath_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int INC_CONST = 2
) (
    input logic               Clock,
    input logic               Reset,
    alu_datapath_unit_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   amux_s;
    logic [WIDTH-1:0]   bmux_s;
    logic [WIDTH-1:0]   sum_s;
    logic [WIDTH-1:0]   diff_s;
    logic [SHAMT_W-1:0] shamt_s;
    logic [WIDTH-1:0]   result_s;
    logic               ovf_s;
    logic               zero_s;
    logic [WIDTH-1:0]   out_r;
    logic               zero_r;
    logic               ovf_r;
    logic               mul_start_s;
    logic               mul_busy_s;
    logic               mul_last_s;
    logic               mul_done_s;
    logic [2*WIDTH-1:0] mul_product_s;

    // Operand registers load independently of the multiplier state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_r <= '0;
            b_r <= '0;
        end else begin
            if (bus.AWrite) begin
                a_r <= bus.Read1;
            end
            if (bus.BWrite) begin
                b_r <= bus.Read2;
            end
        end
    end

    // A-side source select.
    always_comb begin
        amux_s = '0;
        case (bus.ALUAinput)
            ASRC_A:    amux_s = a_r;
            ASRC_PC:   amux_s = bus.PC;
            ASRC_IMM:  amux_s = bus.ExImm;
            ASRC_ZERO: amux_s = '0;
            default:   amux_s = '0;
        endcase
    end

    // B-side source select; select 1 presents the PC increment constant.
    always_comb begin
        bmux_s = '0;
        case (bus.ALUBinput)
            BSRC_B:     bmux_s = b_r;
            BSRC_INC:   bmux_s = WIDTH'(INC_CONST);
            BSRC_IMM:   bmux_s = bus.ExImm;
            BSRC_SHIFT: bmux_s = bus.Shifter;
            default:    bmux_s = '0;
        endcase
    end

    assign sum_s   = amux_s + bmux_s;
    assign diff_s  = amux_s - bmux_s;
    assign shamt_s = bmux_s[SHAMT_W-1:0];

    // Single-cycle ALU; overflow only meaningful for ADD/SUB.
    always_comb begin
        result_s = '0;
        ovf_s    = 1'b0;
        case (bus.ALUOp)
            ALU_ADD: begin
                result_s = sum_s;
                ovf_s    = signed_ovf(amux_s[WIDTH-1], bmux_s[WIDTH-1], sum_s[WIDTH-1]);
            end
            ALU_SUB: begin
                result_s = diff_s;
                ovf_s    = signed_ovf(amux_s[WIDTH-1], ~bmux_s[WIDTH-1], diff_s[WIDTH-1]);
            end
            ALU_AND:  result_s = amux_s & bmux_s;
            ALU_OR:   result_s = amux_s | bmux_s;
            ALU_XOR:  result_s = amux_s ^ bmux_s;
            ALU_NOR:  result_s = ~(amux_s | bmux_s);
            ALU_SLT:  result_s = {{(WIDTH-1){1'b0}}, ($signed(amux_s) < $signed(bmux_s))};
            ALU_SLTU: result_s = {{(WIDTH-1){1'b0}}, (amux_s < bmux_s)};
            ALU_SLL:  result_s = amux_s << shamt_s;
            ALU_SRL:  result_s = amux_s >> shamt_s;
            ALU_SRA:  result_s = $unsigned($signed(amux_s) >>> shamt_s);
            ALU_MUL:  result_s = '0;
            default:  result_s = amux_s;
        endcase
    end

    assign zero_s = (result_s == '0);

    // Launch only from idle with the MUL opcode; a launch pre-empts ALUOutWrite.
    assign mul_start_s = bus.Start && (bus.ALUOp == ALU_MUL) && !mul_busy_s;

    alu_iter_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk          (Clock),
        .rst          (Reset),
        .start        (mul_start_s),
        .multiplicand (amux_s),
        .multiplier   (bmux_s),
        .busy         (mul_busy_s),
        .last         (mul_last_s),
        .done         (mul_done_s),
        .product      (mul_product_s)
    );

    // Result register: multiply completion has priority, single-cycle writes only when idle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_r  <= '0;
            zero_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (mul_last_s) begin
            out_r  <= mul_product_s[WIDTH-1:0];
            zero_r <= (mul_product_s[WIDTH-1:0] == '0);
            ovf_r  <= (mul_product_s[2*WIDTH-1:WIDTH] != '0);
        end else if (bus.ALUOutWrite && !mul_busy_s && !mul_start_s) begin
            out_r  <= result_s;
            zero_r <= zero_s;
            ovf_r  <= ovf_s;
        end
    end

    assign bus.ALUOut      = result_s;
    assign bus.Zero        = zero_s;
    assign bus.OverFlow    = ovf_s;
    assign bus.ALUOutReg   = out_r;
    assign bus.ZeroReg     = zero_r;
    assign bus.OverFlowReg = ovf_r;
    assign bus.Busy        = mul_busy_s;
    assign bus.Done        = mul_done_s;

endmodule

// File: tb/tb_alu_datapath_unit.sv
// Directed bench for alu_datapath_unit: a vector table for the single-cycle
// ALU plus hand-written multiply, back-to-back, abort and WIDTH=32 sequences.
module tb_alu_datapath_unit;
    import alu_pkg::*;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    alu_datapath_unit_if #(.WIDTH(16)) b16 ();
    alu_datapath_unit_if #(.WIDTH(32)) b32 ();

    alu_datapath_unit #(.WIDTH(16), .INC_CONST(2)) dut16 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b16)
    );

    alu_datapath_unit #(.WIDTH(32), .INC_CONST(2)) dut32 (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  asel;
        logic [1:0]  bsel;
        logic [3:0]  op;
        logic [15:0] exp;
        logic        ez;
        logic        eo;
    } vec_t;

    vec_t vecs[19];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic load16(input logic [15:0] a, input logic [15:0] b);
        b16.Read1  = a;
        b16.Read2  = b;
        b16.AWrite = 1'b1;
        b16.BWrite = 1'b1;
        tick();
        b16.AWrite = 1'b0;
        b16.BWrite = 1'b0;
    endtask

    // Waits while Busy is high (bounded), returning the number of busy samples.
    task automatic wait_idle16(output int cyc);
        cyc = 0;
        while (b16.Busy === 1'b1 && cyc < 40) begin
            cyc++;
            tick();
        end
    endtask

    initial begin
        int  cyc;
        int  cyc32;
        bit  held;
        bit  done_seen;

        vecs[0]  = '{16'h1234, 16'h5678, 2'd0, 2'd0, ALU_ADD,  16'h68AC, 1'b0, 1'b0};
        vecs[1]  = '{16'h8000, 16'h0001, 2'd0, 2'd0, ALU_SUB,  16'h7FFF, 1'b0, 1'b1};
        vecs[2]  = '{16'h0001, 16'h0001, 2'd0, 2'd0, ALU_SUB,  16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{16'h8234, 16'h7234, 2'd0, 2'd0, ALU_SLT,  16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{16'h8234, 16'h7234, 2'd0, 2'd0, ALU_SLTU, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{16'h8234, 16'h0004, 2'd0, 2'd0, ALU_SRA,  16'hF823, 1'b0, 1'b0};
        vecs[6]  = '{16'h8234, 16'h0004, 2'd0, 2'd0, ALU_SRL,  16'h0823, 1'b0, 1'b0};
        vecs[7]  = '{16'h8234, 16'h0004, 2'd0, 2'd1, ALU_ADD,  16'h8236, 1'b0, 1'b0};
        vecs[8]  = '{16'h0001, 16'h0004, 2'd0, 2'd0, ALU_SLL,  16'h0010, 1'b0, 1'b0};
        vecs[9]  = '{16'hF0F0, 16'h0FF0, 2'd0, 2'd0, ALU_AND,  16'h00F0, 1'b0, 1'b0};
        vecs[10] = '{16'hF0F0, 16'h0FF0, 2'd0, 2'd0, ALU_OR,   16'hFFF0, 1'b0, 1'b0};
        vecs[11] = '{16'hF0F0, 16'h0FF0, 2'd0, 2'd0, ALU_XOR,  16'hFF00, 1'b0, 1'b0};
        vecs[12] = '{16'hF0F0, 16'h0FF0, 2'd0, 2'd0, ALU_NOR,  16'h000F, 1'b0, 1'b0};
        vecs[13] = '{16'h7FFF, 16'h0001, 2'd0, 2'd0, ALU_ADD,  16'h8000, 1'b0, 1'b1};
        vecs[14] = '{16'h0000, 16'h0005, 2'd1, 2'd0, 4'd12,    16'hBEEF, 1'b0, 1'b0};
        vecs[15] = '{16'h0000, 16'h0005, 2'd3, 2'd0, ALU_ADD,  16'h0005, 1'b0, 1'b0};
        vecs[16] = '{16'h1234, 16'h5678, 2'd0, 2'd0, ALU_MUL,  16'h0000, 1'b1, 1'b0};
        vecs[17] = '{16'h0100, 16'h0000, 2'd0, 2'd3, ALU_ADD,  16'h1000, 1'b0, 1'b0};
        vecs[18] = '{16'h0000, 16'h0000, 2'd2, 2'd2, ALU_ADD,  16'h2000, 1'b0, 1'b0};

        Reset = 1'b1;
        b16.PC = 16'hBEEF; b16.ExImm = 16'h1000; b16.Shifter = 16'h0F00;
        b16.Read1 = '0; b16.Read2 = '0; b16.AWrite = 1'b0; b16.BWrite = 1'b0;
        b16.ALUAinput = 2'd0; b16.ALUBinput = 2'd0; b16.ALUOp = ALU_ADD;
        b16.ALUOutWrite = 1'b0; b16.Start = 1'b0;
        b32.PC = '0; b32.ExImm = '0; b32.Shifter = '0;
        b32.Read1 = '0; b32.Read2 = '0; b32.AWrite = 1'b0; b32.BWrite = 1'b0;
        b32.ALUAinput = 2'd0; b32.ALUBinput = 2'd0; b32.ALUOp = ALU_ADD;
        b32.ALUOutWrite = 1'b0; b32.Start = 1'b0;
        tick();
        tick();
        Reset = 1'b0;

        chk("rst_outreg", b16.ALUOutReg, 16'h0000);
        chk("rst_flags", {b16.ZeroReg, b16.OverFlowReg, b16.Busy, b16.Done}, 4'b0000);
        chk("rst_a_plus_b", b16.ALUOut, 16'h0000);

        // Single-cycle vectors: combinational result, then registered capture.
        for (int i = 0; i < 19; i++) begin
            load16(vecs[i].a, vecs[i].b);
            b16.ALUAinput = vecs[i].asel;
            b16.ALUBinput = vecs[i].bsel;
            b16.ALUOp     = vecs[i].op;
            #1;
            chk($sformatf("v%0d_out", i), b16.ALUOut, vecs[i].exp);
            chk($sformatf("v%0d_zero_ovf", i), {b16.Zero, b16.OverFlow}, {vecs[i].ez, vecs[i].eo});
            b16.ALUOutWrite = 1'b1;
            tick();
            b16.ALUOutWrite = 1'b0;
            chk($sformatf("v%0d_reg", i), {b16.ALUOutReg, b16.ZeroReg, b16.OverFlowReg},
                {vecs[i].exp, vecs[i].ez, vecs[i].eo});
        end
        b16.ALUAinput = 2'd0;
        b16.ALUBinput = 2'd0;

        // Multiply 0x0123*0x0045 with Start+ALUOutWrite together and writes while busy.
        load16(16'h0123, 16'h0045);
        b16.ALUOp = ALU_MUL;
        b16.Start = 1'b1;
        b16.ALUOutWrite = 1'b1;
        tick();
        b16.Start = 1'b0;
        chk("start_wins", b16.ALUOutReg, 16'h2000);
        cyc = 0;
        held = 1'b1;
        while (b16.Busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (b16.ALUOutReg !== 16'h2000 || b16.Done !== 1'b0) held = 1'b0;
            b16.ALUOp = ALU_ADD;
            b16.ALUOutWrite = 1'b1;
            b16.Read1 = 16'hFFFF;
            b16.AWrite = 1'b1;
            tick();
        end
        b16.ALUOutWrite = 1'b0;
        b16.AWrite = 1'b0;
        chk("mul1_busy_cycles", cyc, 16);
        chk("mul1_hold_while_busy", held, 1'b1);
        chk("mul1_done", b16.Done, 1'b1);
        chk("mul1_result", {b16.ALUOutReg, b16.ZeroReg, b16.OverFlowReg}, {16'h4E6F, 1'b0, 1'b0});
        tick();
        chk("mul1_done_once", b16.Done, 1'b0);
        chk("mul1_result_kept", b16.ALUOutReg, 16'h4E6F);

        // Overflowing multiply, relaunched during its Done cycle.
        load16(16'h1234, 16'h5678);
        b16.ALUOp = ALU_MUL;
        b16.Start = 1'b1;
        tick();
        b16.Start = 1'b0;
        wait_idle16(cyc);
        chk("mul2_busy_cycles", cyc, 16);
        chk("mul2_done", b16.Done, 1'b1);
        chk("mul2_result", {b16.ALUOutReg, b16.ZeroReg, b16.OverFlowReg}, {16'h0060, 1'b0, 1'b1});
        b16.Start = 1'b1;
        tick();
        b16.Start = 1'b0;
        chk("b2b_busy_done", {b16.Busy, b16.Done}, 2'b10);
        wait_idle16(cyc);
        chk("b2b_busy_cycles", cyc, 16);
        chk("b2b_result", {b16.ALUOutReg, b16.OverFlowReg, b16.Done}, {16'h0060, 1'b1, 1'b1});
        tick();

        // Start with a non-MUL opcode does nothing.
        b16.ALUOp = ALU_ADD;
        b16.Start = 1'b1;
        tick();
        b16.Start = 1'b0;
        chk("start_not_mul", {b16.Busy, b16.ALUOutReg}, {1'b0, 16'h0060});

        // WIDTH=32 multiply.
        b32.Read1 = 32'h0001_2345;
        b32.Read2 = 32'h0000_0010;
        b32.AWrite = 1'b1;
        b32.BWrite = 1'b1;
        tick();
        b32.AWrite = 1'b0;
        b32.BWrite = 1'b0;
        b32.ALUBinput = 2'd1;
        #1;
        chk("w32_add_inc", b32.ALUOut, 32'h0001_2347);
        b32.ALUBinput = 2'd0;
        b32.ALUOp = ALU_MUL;
        b32.Start = 1'b1;
        tick();
        b32.Start = 1'b0;
        cyc32 = 0;
        while (b32.Busy === 1'b1 && cyc32 < 80) begin
            cyc32++;
            tick();
        end
        chk("w32_busy_cycles", cyc32, 32);
        chk("w32_done", b32.Done, 1'b1);
        chk("w32_result", {b32.ALUOutReg, b32.ZeroReg, b32.OverFlowReg}, {32'h0012_3450, 1'b0, 1'b0});

        // Reset during MUL cycle 7 aborts the multiply.
        load16(16'h0123, 16'h0045);
        b16.ALUOp = ALU_MUL;
        b16.Start = 1'b1;
        tick();
        b16.Start = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("abort_busy_before", b16.Busy, 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("abort_busy", b16.Busy, 1'b0);
        chk("abort_outreg", {b16.ALUOutReg, b16.ZeroReg, b16.OverFlowReg}, {16'h0000, 1'b0, 1'b0});
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (b16.Done !== 1'b0 || b16.Busy !== 1'b0) done_seen = 1'b1;
            tick();
        end
        chk("abort_no_done", done_seen, 1'b0);
        b16.ALUOp = ALU_ADD;
        #1;
        chk("abort_operands_cleared", b16.ALUOut, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_datapath_unit.md
Name: alu_datapath_unit

Overview:
- Parametrised successor to the multicycle A/B/ALU datapath slice: operand registers A and B, A-side and B-side source muxes, an ALU with Zero/OverFlow flags, and a registered ALUOut.
- Adds generic WIDTH, an extended op set (signed/unsigned compare, shifts) and an iterative multi-cycle multiply with a Start/Busy/Done handshake.
- Sits between the register file, PC and immediate/shifter units and the control FSM.

Parameters:
- WIDTH, 16, datapath width in bits (≥4, power of two).
- INC_CONST, 2, constant presented on B-mux select 1 (PC increment).
- SHAMT_W, clog2(WIDTH), localparam, shift-amount bits taken from B operand LSBs.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- PC  in  WIDTH  program counter value.
- Read1  in  WIDTH  register file port 1, loaded into A.
- Read2  in  WIDTH  register file port 2, loaded into B.
- ExImm  in  WIDTH  extended immediate.
- Shifter  in  WIDTH  shifter-unit output.
- AWrite  in  1  load A from Read1.
- BWrite  in  1  load B from Read2.
- ALUAinput  in  2  A-mux select: 0 A, 1 PC, 2 ExImm, 3 zero.
- ALUBinput  in  2  B-mux select: 0 B, 1 INC_CONST, 2 ExImm, 3 Shifter.
- ALUOp  in  4  operation code.
- ALUOutWrite  in  1  capture single-cycle result into ALUOutReg.
- Start  in  1  launch multiply (only when ALUOp = MUL).
- ALUOut  out  WIDTH  combinational result.
- Zero  out  1  ALUOut == 0, combinational.
- OverFlow  out  1  signed overflow of the current add/sub, combinational.
- ALUOutReg  out  WIDTH  registered result.
- ZeroReg  out  1  Zero captured with ALUOutReg.
- OverFlowReg  out  1  OverFlow captured with ALUOutReg.
- Busy  out  1  multiply in progress.
- Done  out  1  one-cycle pulse; multiply result valid in ALUOutReg.

Behaviour:
- Reset: A, B, ALUOutReg = 0; ZeroReg, OverFlowReg, Busy, Done = 0; FSM = IDLE. Reset overrides all other inputs in the same edge.
- A and B load on the edge when AWrite/BWrite = 1, in any FSM state. The multiply uses its own captured operands, so these loads do not affect an in-flight multiply.
- ALUOp encoding, all results mod 2^WIDTH:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT (signed, result 0/1), 7 SLTU (unsigned, result 0/1).
  - 8 SLL, 9 SRL, 10 SRA: shift by B[SHAMT_W-1:0].
  - 11 MUL: ALUOut shows 0 combinationally.
  - 12–15 reserved: ALUOut = A-mux value.
- OverFlow: ADD is 1 when the operand signs are equal and the result sign differs. SUB is 1 when the operand signs differ and the result sign differs from A. All other ops give 0.
- Single-cycle path: when ALUOutWrite = 1 and the FSM is IDLE, ALUOutReg, ZeroReg and OverFlowReg capture ALUOut, Zero and OverFlow at the edge. Latency is 1 edge. ALUOutWrite is ignored while Busy.
- Multiply FSM, states IDLE and MUL:
  - IDLE→MUL on an edge with Start = 1 and ALUOp = 11. That edge captures the multiplicand = A-mux, multiplier = B-mux, a 2·WIDTH-bit accumulator = 0 and count = WIDTH-1.
  - MUL: one shift-add iteration per edge; Busy = 1 for exactly WIDTH cycles.
  - On the edge completing the final iteration:
    - ALUOutReg = low WIDTH bits of the product.
    - ZeroReg = (low bits == 0).
    - OverFlowReg = (high WIDTH bits != 0), unsigned.
    - Done = 1 for the following cycle; FSM → IDLE.
  - Start while Busy is ignored. Start during the Done cycle is accepted, giving back-to-back multiplies.
  - Start with ALUOp ≠ 11 is ignored.
  - Start and ALUOutWrite asserted together in IDLE: Start wins; no single-cycle capture.
- Reset mid-multiply aborts the operation: Busy = 0 the next cycle, Done is never pulsed, ALUOutReg = 0.
- Operands are treated as unsigned for MUL; the low half is sign-agnostic.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUOp localparams (ALU_ADD … ALU_MUL);
  - the mux-select localparams (ASRC_*, BSRC_*);
  - the FSM state encoding.
- One sub-module, alu_iter_mul (WIDTH-parametrised shift-add multiplier with Start/Busy/Done). The top level contains the muxes, registers, single-cycle ALU and result-register arbitration.

Test Plan:
- WIDTH=16, load A=0x1234, B=0x5678, ALUOp=ADD, ALUOutWrite → ALUOutReg=0x68AC, ZeroReg=0, OverFlowReg=0.
- A=0x8000, B=0x0001, SUB → ALUOut=0x7FFF, OverFlow=1. Then A=0x0001, B=0x0001, SUB → ALUOut=0x0000, Zero=1, OverFlow=0.
- A=0x8234, B=0x7234: SLT → 0x0001; SLTU → 0x0000. B=0x0004: SRA → 0xF823, SRL → 0x0823; ALUBinput=1 with ADD → 0x8236.
- A=0x0123, B=0x0045, MUL+Start:
  - Busy high exactly 16 cycles, then Done for 1 cycle;
  - ALUOutReg=0x4E6F, OverFlowReg=0;
  - ALUOutWrite pulses while Busy change nothing.
- A=0x1234, B=0x5678, MUL → ALUOutReg=0x0060, OverFlowReg=1. Start again during the Done cycle → second multiply starts immediately.
- Reset asserted in MUL cycle 7 → Busy=0 next cycle, Done never pulses, ALUOutReg=0. Repeat the bench with WIDTH=32: 0x00012345*0x00000010 → ALUOutReg=0x00123450.
